// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: funct3 codes, 2-bit counter
// encodings and the saturating counter update.
package branch_predict_unit_pkg;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT   = 2'b00;
  localparam cnt_t CNT_WNT   = 2'b01;
  localparam cnt_t CNT_WT    = 2'b10;
  localparam cnt_t CNT_ST    = 2'b11;
  localparam cnt_t CNT_RESET = CNT_WNT;

  function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
    cnt_t res;
    res = cnt;
    if (taken && cnt != CNT_ST) res = cnt + 2'd1;
    else if (!taken && cnt != CNT_SNT) res = cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-facing bundle of the branch predict unit.
// Handshake: no ready; a request is taken whenever res_valid=1 and res_flush=0,
// one per cycle, and its result appears as a one-cycle res_done pulse after the next edge.
interface branch_predict_unit_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            res_valid;
  logic            res_flush;
  logic [XLEN-1:0] res_pc;
  logic [2:0]      res_funct3;
  logic [XLEN-1:0] res_rs1;
  logic [XLEN-1:0] res_rs2;
  logic [XLEN-1:0] res_imm;
  logic            res_pred_taken;
  logic            res_done;
  logic            res_taken;
  logic            res_mispredict;
  logic [XLEN-1:0] res_redirect_pc;
  logic            res_illegal;

  modport master (
    output pred_pc, res_valid, res_flush, res_pc, res_funct3, res_rs1, res_rs2,
           res_imm, res_pred_taken,
    input  pred_taken, res_done, res_taken, res_mispredict, res_redirect_pc, res_illegal
  );

  modport slave (
    input  pred_pc, res_valid, res_flush, res_pc, res_funct3, res_rs1, res_rs2,
           res_imm, res_pred_taken,
    output pred_taken, res_done, res_taken, res_mispredict, res_redirect_pc, res_illegal
  );
endinterface

// File: rtl/branch_predict_unit_compare.sv
// Full-width RV32 branch condition evaluation; funct3 2/3 flagged illegal.
module branch_compare
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken,
  output logic            illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BR_BEQ:  taken = (rs1 == rs2);
      BR_BNE:  taken = (rs1 != rs2);
      BR_BLT:  taken = ($signed(rs1) < $signed(rs2));
      BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: taken = (rs1 < rs2);
      BR_BGEU: taken = (rs1 >= rs2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a direct-mapped 2-bit counter predictor.
// Optional BRANCH_STATS_EN adds resolve/mispredict counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64
) (
  input  logic clk,
  input  logic rst_n,
  branch_predict_unit_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  cnt_t            bht [BHT_ENTRIES];
  logic [IDX-1:0]  pred_idx;
  logic [IDX-1:0]  res_idx;
  logic            cmp_taken;
  logic            cmp_illegal;
  logic            accept;
  logic            update;
  logic            mispredict;
  logic [XLEN-1:0] next_pc;
  logic            unused_pred_bits;

  assign pred_idx       = bus.pred_pc[IDX+1:2];
  assign res_idx        = bus.res_pc[IDX+1:2];
  assign bus.pred_taken = bht[pred_idx][1];
  assign unused_pred_bits = ^{bus.pred_pc[XLEN-1:IDX+2], bus.pred_pc[1:0]};

  branch_compare #(.XLEN(XLEN)) u_compare (
    .rs1     (bus.res_rs1),
    .rs2     (bus.res_rs2),
    .funct3  (bus.res_funct3),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Illegal requests still complete, but as not-taken and without training.
  assign accept     = bus.res_valid & ~bus.res_flush;
  assign update     = accept & ~cmp_illegal;
  assign mispredict = update & (cmp_taken != bus.res_pred_taken);
  assign next_pc    = (update && cmp_taken) ? bus.res_pc + bus.res_imm
                                            : bus.res_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_RESET;
    end else if (update) begin
      bht[res_idx] <= cnt_next(bht[res_idx], cmp_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_done        <= 1'b0;
      bus.res_taken       <= 1'b0;
      bus.res_mispredict  <= 1'b0;
      bus.res_illegal     <= 1'b0;
      bus.res_redirect_pc <= '0;
    end else begin
      bus.res_done       <= accept;
      bus.res_taken      <= update & cmp_taken;
      bus.res_mispredict <= mispredict;
      bus.res_illegal    <= accept & cmp_illegal;
      if (accept) bus.res_redirect_pc <= next_pc;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update)     stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit with a behavioural predictor model.
module tb_branch_predict_unit;

  localparam int XLEN = 32;
  localparam int BHT  = 64;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   model [BHT];
  int   exp_branches;
  int   exp_mis;
  logic [35:0] exp_q[$];

  branch_predict_unit_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(BHT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % BHT);
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BHT; i++) model[i] = 1;
    exp_branches = 0;
    exp_mis = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    bus.res_valid = 0; bus.res_flush = 0; bus.res_pc = 0; bus.res_funct3 = 0;
    bus.res_rs1 = 0; bus.res_rs2 = 0; bus.res_imm = 0; bus.res_pred_taken = 0;
    bus.pred_pc = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // Drives one request at a negedge and records what the model expects after the edge.
  task automatic send(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic pt,
                      input logic fl);
    logic ill, tk, mis;
    logic [31:0] rd;
    bus.res_valid = 1; bus.res_flush = fl; bus.res_pc = pc; bus.res_funct3 = f3;
    bus.res_rs1 = a; bus.res_rs2 = b; bus.res_imm = imm; bus.res_pred_taken = pt;
    if (fl) begin
      exp_q.push_back(36'd0);
    end else begin
      ill = (f3 == 3'd2 || f3 == 3'd3);
      tk  = ill ? 1'b0 : ref_taken(f3, a, b);
      mis = !ill && (tk != pt);
      rd  = tk ? pc + imm : pc + 32'd4;
      exp_q.push_back({1'b1, tk, mis, ill, rd});
      if (!ill) begin
        exp_branches++;
        if (mis) exp_mis++;
        if (tk) model[idx_of(pc)] = (model[idx_of(pc)] == 3) ? 3 : model[idx_of(pc)] + 1;
        else    model[idx_of(pc)] = (model[idx_of(pc)] == 0) ? 0 : model[idx_of(pc)] - 1;
      end
    end
  endtask

  task automatic check_out(input string name);
    logic [35:0] exp, got;
    got = {bus.res_done, bus.res_taken, bus.res_mispredict, bus.res_illegal,
           bus.res_redirect_pc};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected result queued", name);
      return;
    end
    exp = exp_q.pop_front();
    if (exp[35]) begin
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got done/tk/mis/ill=%b redirect=%h, want %b redirect=%h",
                 name, got[35:32], got[31:0], exp[35:32], exp[31:0]);
      end
    end else if (got[35] !== 1'b0) begin
      errors++;
      $display("FAIL %s: res_done=%b, want 0", name, got[35]);
    end
  endtask

  task automatic step(input string name);
    @(negedge clk);
    bus.res_valid = 0;
    bus.res_flush = 0;
    check_out(name);
  endtask

  task automatic check_pred(input logic [31:0] pc, input string name);
    logic exp;
    bus.pred_pc = pc;
    #1;
    exp = (model[idx_of(pc)] >= 2);
    checks++;
    if (bus.pred_taken !== exp) begin
      errors++;
      $display("FAIL %s: pred_taken=%b for pc=%h, want %b", name, bus.pred_taken, pc, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.res_done, bus.res_taken, bus.res_mispredict, bus.res_illegal} !== 4'b0 ||
        bus.res_redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b redirect=%h, want 0000 and 0",
               {bus.res_done, bus.res_taken, bus.res_mispredict, bus.res_illegal},
               bus.res_redirect_pc);
    end
    for (int i = 0; i < 4; i++) check_pred($urandom, "reset_pred");
  endtask

  task automatic test_beq();
    check_pred(32'h100, "beq_pred_before");
    @(negedge clk);
    send(32'h100, 3'd0, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0);
    step("beq_taken");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      send(32'h204, 3'd0, 32'd7, 32'd7, 32'h40, bus.pred_taken, 1'b0);
      step("sat_taken");
      check_pred(32'h204, "sat_pred");
    end
    @(negedge clk);
    send(32'h204, 3'd1, 32'd3, 32'd3, 32'h40, 1'b1, 1'b0);
    step("sat_not_taken");
    check_pred(32'h204, "sat_pred_after_nt");
  endtask

  task automatic test_read_before_write();
    @(negedge clk);
    bus.pred_pc = 32'h14;
    send(32'h14, 3'd0, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rbw_pre_update: pred_taken=%b, want 0", bus.pred_taken);
    end
    step("rbw_result");
    check_pred(32'h14, "rbw_post_update");
  endtask

  task automatic test_signed_unsigned();
    @(negedge clk);
    send(32'h30C, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b0);
    step("blt_signed");
    send(32'h30C, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b0, 1'b0);
    step("bltu_unsigned");
    send(32'h30C, 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 1'b1, 1'b0);
    step("bge_signed");
    send(32'h30C, 3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h10, 1'b0, 1'b0);
    step("bgeu_unsigned");
  endtask

  task automatic test_illegal();
    @(negedge clk);
    send(32'h40, 3'd0, 32'd0, 32'd0, 32'h8, 1'b0, 1'b0);
    step("ill_setup");
    check_pred(32'h40, "ill_setup_pred");
    send(32'h40, 3'd2, 32'd9, 32'd9, 32'h8, 1'b1, 1'b0);
    step("illegal_f3_2");
    send(32'h40, 3'd3, 32'd9, 32'd4, 32'h8, 1'b0, 1'b0);
    step("illegal_f3_3");
    check_pred(32'h40, "ill_counter_kept");
  endtask

  task automatic test_flush();
    @(negedge clk);
    send(32'h80, 3'd0, 32'd2, 32'd2, 32'h8, 1'b0, 1'b1);
    step("flush_no_done");
    check_pred(32'h80, "flush_counter_kept");
  endtask

  task automatic test_wrap();
    @(negedge clk);
    send(32'hFFFF_FFFC, 3'd0, 32'd1, 32'd1, 32'd8, 1'b1, 1'b0);
    step("wrap_taken");
    send(32'hFFFF_FFFC, 3'd1, 32'd1, 32'd1, 32'd8, 1'b0, 1'b0);
    step("wrap_not_taken");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    send(32'h1A0, 3'd0, 32'd1, 32'd1, 32'h4, 1'b0, 1'b0);
    @(negedge clk); check_out("b2b_t1");
    send(32'h1A0, 3'd0, 32'd1, 32'd1, 32'h4, 1'b0, 1'b0);
    @(negedge clk); check_out("b2b_t2");
    check_pred(32'h1A0, "b2b_pred_st");
    send(32'h1A0, 3'd1, 32'd1, 32'd1, 32'h4, 1'b1, 1'b0);
    @(negedge clk); check_out("b2b_n1");
    send(32'h1A0, 3'd1, 32'd1, 32'd1, 32'h4, 1'b1, 1'b0);
    step("b2b_n2");
    check_pred(32'h1A0, "b2b_pred_after");
  endtask

  task automatic test_random();
    logic [31:0] a, b, pc;
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = {$urandom_range(0, 3) == 0 ? $urandom : 32'd0} ^ (32'($urandom_range(0, 7)) << 2);
      send(pc, 3'($urandom_range(0, 7)), a, b, $urandom, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0);
      @(negedge clk);
      check_out("random_result");
      check_pred($urandom, "random_pred");
    end
    bus.res_valid = 0;
`ifdef BRANCH_STATS_EN
    checks++;
    if (stat_branches !== 32'(exp_branches) || stat_mispredicts !== 32'(exp_mis)) begin
      errors++;
      $display("FAIL random_stats: branches=%0d mis=%0d, want %0d %0d",
               stat_branches, stat_mispredicts, exp_branches, exp_mis);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    send(32'h8, 3'd0, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0);
    send(32'h8, 3'd0, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (bus.res_done !== 1'b0 || bus.pred_taken !== 1'b0 && bus.pred_pc[7:2] == 6'd2) begin
      errors++;
      $display("FAIL reset_mid: res_done=%b, want 0", bus.res_done);
    end
    bus.res_valid = 0;
    @(negedge clk);
    rst_n = 1;
    check_pred(32'h8, "reset_mid_table");
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(32'h100 + 32'(i * 4), 3'd0, 32'd1, 32'd1, 32'h8, i >= 3, 1'b0);
      step("stats_legal");
    end
    send(32'h100, 3'd2, 32'd1, 32'd1, 32'h8, 1'b0, 1'b0);
    step("stats_illegal");
    checks++;
    if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
      errors++;
      $display("FAIL stats_count: branches=%0d mis=%0d, want 10 3",
               stat_branches, stat_mispredicts);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_beq();
    test_saturation();
    test_read_before_write();
    test_signed_unsigned();
    test_illegal();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
